// File: rtl/pfa_pkg.sv
// Shared types for the pfa32 adder arbiter.
// Word width, adder response bundle and carry helper.
package pfa_pkg;

    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef struct packed {
        word_t sum;
        logic  carry;
    } add_rsp_t;

    // The adder has no carry port, so rebuild it from the operand/sum MSBs.
    function automatic logic carry_out(
        input word_t a,
        input word_t b,
        input word_t s
    );
        logic am;
        logic bm;
        logic sm;
        am = a[DATA_W-1];
        bm = b[DATA_W-1];
        sm = s[DATA_W-1];
        return (am & bm) | ((am ^ bm) & ~sm);
    endfunction

endpackage

// File: rtl/pfa32.sv
// 32-bit ripple-carry adder, sum only, no carry-in/out ports.
// Shared arithmetic resource behind pfa32_arbiter.
module pfa32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic [31:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < 32; i++) begin : g_bit
        assign sum[i] = a[i] ^ b[i] ^ c[i];
        if (i < 31) begin : g_cy
            assign c[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & c[i]);
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after rr_ptr.
// Rotate the request vector by the pointer, then a fixed priority search.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [NUM_REQ-1:0] rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      pos;

    always_comb begin
        rot = NUM_REQ'({req, req} >> rr_ptr);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = ID_W'(k);
            end
        end
        pos = {1'b0, rr_ptr} + {1'b0, off};
        if (pos >= (ID_W+1)'(NUM_REQ)) begin
            pos = pos - (ID_W+1)'(NUM_REQ);
        end
        gnt_idx = pos[ID_W-1:0];
        gnt_any = |req;
    end

endmodule

// File: rtl/pfa32_arbiter.sv
// Round-robin sharing of one pfa32 adder among NUM_REQ requesters,
// with a single registered, backpressured response stage.
module pfa32_arbiter
    import pfa_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [31:0]        req_a [NUM_REQ],
    input  logic [31:0]        req_b [NUM_REQ],
    output logic [NUM_REQ-1:0] req_ready,
    output logic               rsp_valid,
    output logic [31:0]        rsp_sum,
    output logic               rsp_carry,
    output logic [ID_W-1:0]    rsp_id,
    input  logic               rsp_ready
);

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] nxt_ptr;
    logic [ID_W-1:0] gnt_idx;
    logic            gnt_any;
    logic            accept;
    logic            fire;

    word_t    op_a;
    word_t    op_b;
    word_t    add_sum;
    add_rsp_t nxt_rsp;

    add_rsp_t        rsp_q;
    logic [ID_W-1:0] id_q;
    logic            valid_q;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign accept = ~valid_q | rsp_ready;
    assign fire   = gnt_any & accept;

    always_comb begin
        req_ready = '0;
        if (fire) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign op_a = req_a[gnt_idx];
    assign op_b = req_b[gnt_idx];

    pfa32 u_add (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_comb begin
        nxt_rsp.sum   = add_sum;
        nxt_rsp.carry = carry_out(op_a, op_b, add_sum);
        if (gnt_idx == ID_W'(NUM_REQ - 1)) begin
            nxt_ptr = '0;
        end else begin
            nxt_ptr = gnt_idx + 1'b1;
        end
    end

    // Fill wins over drain, so a simultaneous accept/refill has no bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_q   <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
            rr_ptr  <= '0;
        end else if (fire) begin
            rsp_q   <= nxt_rsp;
            id_q    <= gnt_idx;
            valid_q <= 1'b1;
            rr_ptr  <= nxt_ptr;
        end else if (rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign rsp_valid = valid_q;
    assign rsp_sum   = rsp_q.sum;
    assign rsp_carry = rsp_q.carry;
    assign rsp_id    = id_q;

    a_gnt_onehot : assert property (@(posedge clk) $onehot0(req_ready));

endmodule
